// File: rtl/mult_share_arbiter_if.sv
// Requester/response bundle for the shared-multiplier arbiter.
// The master side is the client/consumer; the slave side is the arbiter.
interface mult_share_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]   req;
  logic [4*NREQ-1:0] a_in;
  logic [4*NREQ-1:0] b_in;
  logic [NREQ-1:0]   gnt;
  logic              rsp_valid;
  logic [IDW-1:0]    rsp_id;
  logic [7:0]        rsp_y;
  logic              rsp_ready;
  logic              busy;

  modport master (
    output req, a_in, b_in, rsp_ready,
    input  gnt, rsp_valid, rsp_id, rsp_y, busy
  );

  modport slave (
    input  req, a_in, b_in, rsp_ready,
    output gnt, rsp_valid, rsp_id, rsp_y, busy
  );
endinterface

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter that time-shares one 4x4 multiplier among NREQ clients,
// one operation per IDLE -> MUL -> RESP pass.
module bit4_multiplier (
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic [7:0] Y
);
  assign Y = {4'b0, A} * {4'b0, B};
endmodule

module mult_share_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input logic                clk,
  input logic                rst_n,
  mult_share_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, MUL, RESP} state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] ptr, cur_id, win, cand;
  logic           win_vld;
  logic [3:0]     op_a, op_b;
  logic [7:0]     y;
  logic           cap, load, done;
  logic [3:0]     a_lane [NREQ];
  logic [3:0]     b_lane [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    assign a_lane[i] = bus.a_in[4*i +: 4];
    assign b_lane[i] = bus.b_in[4*i +: 4];
  end

  // First requester found scanning upward from ptr, wrapping mod NREQ.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    cand    = '0;
    for (int off = 0; off < NREQ; off++) begin
      cand = IDW'((int'(ptr) + off) % NREQ);
      if (!win_vld && bus.req[cand]) begin
        win     = cand;
        win_vld = 1'b1;
      end
    end
  end

  bit4_multiplier u_mul (.A(op_a), .B(op_b), .Y(y));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cap       = 1'b0;
    load      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: if (win_vld) begin
        cap       = 1'b1;
        state_nxt = MUL;
      end
      MUL: begin
        load      = 1'b1;
        state_nxt = RESP;
      end
      RESP: if (bus.rsp_valid && bus.rsp_ready) begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr           <= '0;
      cur_id        <= '0;
      op_a          <= '0;
      op_b          <= '0;
      bus.gnt       <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_y     <= '0;
      bus.rsp_id    <= '0;
    end else begin
      // gnt is a single-cycle pulse marking operand capture
      bus.gnt <= cap ? (NREQ'(1) << win) : '0;
      if (cap) begin
        op_a   <= a_lane[win];
        op_b   <= b_lane[win];
        cur_id <= win;
      end
      if (load) begin
        bus.rsp_y     <= y;
        bus.rsp_id    <= cur_id;
        bus.rsp_valid <= 1'b1;
      end
      if (done) begin
        bus.rsp_valid <= 1'b0;
        ptr           <= (cur_id == IDW'(NREQ-1)) ? '0 : cur_id + 1'b1;
      end
    end
  end

  assign bus.busy = (state != IDLE);
endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter: latency, round-robin order,
// backpressure, async reset and operand boundaries.
module tb_mult_share_arbiter;
  logic clk;
  logic rst_n;
  int   n_run;
  int   n_fail;

  mult_share_arbiter_if #(.NREQ(4), .IDW(2)) bus ();

  mult_share_arbiter #(.NREQ(4), .IDW(2)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [3:0] a, input logic [3:0] b);
    bus.a_in[4*i +: 4] = a;
    bus.b_in[4*i +: 4] = b;
  endtask

  task automatic chk_rsp(input string tag, input logic [1:0] id, input logic [7:0] y);
    chk({tag, "_valid"}, 32'(bus.rsp_valid), 32'd1);
    chk({tag, "_id"},    32'(bus.rsp_id),    32'(id));
    chk({tag, "_y"},     32'(bus.rsp_y),     32'(y));
  endtask

  logic [3:0] va [4];
  logic [3:0] vb [4];
  logic [7:0] vy [4];
  int         fair_seq [4];

  initial begin
    n_run = 0;
    n_fail = 0;
    va = '{4'd5, 4'd10, 4'd13, 4'd15};
    vb = '{4'd11, 4'd12, 4'd2, 4'd15};
    vy = '{8'd55, 8'd120, 8'd26, 8'd225};
    fair_seq = '{0, 3, 0, 3};

    rst_n = 1'b0;
    bus.req = '0;
    bus.a_in = '0;
    bus.b_in = '0;
    bus.rsp_ready = 1'b0;
    #2;
    chk("rst_gnt",   32'(bus.gnt),       32'd0);
    chk("rst_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_y",     32'(bus.rsp_y),     32'd0);
    chk("rst_id",    32'(bus.rsp_id),    32'd0);
    chk("rst_busy",  32'(bus.busy),      32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // single request on lane 1
    set_op(1, 4'd7, 4'd15);
    bus.req = 4'b0010;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("s_gnt",  32'(bus.gnt),  32'b0010);
    chk("s_busy", 32'(bus.busy), 32'd1);
    bus.req = '0;
    @(negedge clk);
    chk("s_gnt_pulse", 32'(bus.gnt), 32'd0);
    chk_rsp("s", 2'd1, 8'd105);
    @(negedge clk);
    chk("s_done_valid", 32'(bus.rsp_valid), 32'd0);
    chk("s_done_busy",  32'(bus.busy),      32'd0);

    // restart so ptr is back at 0, then all four request together
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) set_op(i, va[i], vb[i]);
    bus.req = 4'hF;
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("all_gnt%0d", k), 32'(bus.gnt), 32'd1 << k);
      bus.req[k] = 1'b0;
      @(negedge clk);
      chk($sformatf("all_gnt_off%0d", k), 32'(bus.gnt), 32'd0);
      chk_rsp($sformatf("all%0d", k), 2'(k), vy[k]);
      @(negedge clk);
      chk($sformatf("all_idle%0d", k), 32'(bus.busy), 32'd0);
    end

    // fairness: lanes 0 and 3 held high
    bus.req = 4'b1001;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("fair_gnt%0d", k), 32'(bus.gnt), 32'd1 << fair_seq[k]);
      if (k == 3) bus.req = '0;
      @(negedge clk);
      chk($sformatf("fair_id%0d", k), 32'(bus.rsp_id), 32'(fair_seq[k]));
      @(negedge clk);
    end

    // backpressure on lane 2 with lane 0 waiting
    set_op(2, 4'd10, 4'd12);
    bus.req = 4'b0100;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    chk("bp_gnt", 32'(bus.gnt), 32'b0100);
    set_op(0, 4'd0, 4'd13);
    bus.req = 4'b0001;
    @(negedge clk);
    chk_rsp("bp0", 2'd2, 8'd120);
    for (int c = 1; c < 5; c++) begin
      @(negedge clk);
      chk_rsp($sformatf("bp%0d", c), 2'd2, 8'd120);
      chk($sformatf("bp_nogrant%0d", c), 32'(bus.gnt), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_hs_valid", 32'(bus.rsp_valid), 32'd0);
    chk("bp_hs_gnt",   32'(bus.gnt),       32'd0);
    @(negedge clk);
    chk("zero_gnt", 32'(bus.gnt), 32'b0001);
    bus.req = '0;
    @(negedge clk);
    chk_rsp("zero", 2'd0, 8'd0);
    @(negedge clk);
    chk("zero_done", 32'(bus.rsp_valid), 32'd0);

    // req pulse confined to MUL must not be granted
    set_op(2, 4'd15, 4'd15);
    bus.req = 4'b0100;
    @(negedge clk);
    chk("pulse_gnt", 32'(bus.gnt), 32'b0100);
    bus.req = 4'b0010;
    #2 bus.req = '0;
    @(negedge clk);
    chk_rsp("max", 2'd2, 8'd225);
    @(negedge clk);
    chk("pulse_hs", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    chk("pulse_nogrant0", 32'(bus.gnt), 32'd0);
    @(negedge clk);
    chk("pulse_nogrant1", 32'(bus.gnt),  32'd0);
    chk("pulse_idle",     32'(bus.busy), 32'd0);

    // reset during MUL: ptr was 3, so lane 3 wins first
    set_op(3, 4'd9, 4'd9);
    bus.req = 4'b1000;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    chk("mr_gnt", 32'(bus.gnt), 32'b1000);
    set_op(2, 4'd6, 4'd7);
    bus.req = 4'b1100;
    #1 rst_n = 1'b0;
    #1;
    chk("mr_gnt0",   32'(bus.gnt),       32'd0);
    chk("mr_busy0",  32'(bus.busy),      32'd0);
    chk("mr_valid0", 32'(bus.rsp_valid), 32'd0);
    chk("mr_y0",     32'(bus.rsp_y),     32'd0);
    chk("mr_id0",    32'(bus.rsp_id),    32'd0);
    @(negedge clk);
    chk("mr_no_rsp", 32'(bus.rsp_valid), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mr_regrant", 32'(bus.gnt), 32'b0100);
    bus.req = '0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk_rsp("mr", 2'd2, 8'd42);
    @(negedge clk);
    chk("mr_done", 32'(bus.rsp_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/mult_share_arbiter.md
# mult_share_arbiter

Round-robin arbiter and sequencer that shares one combinational 4x4 unsigned multiplier among NREQ requesters. Each requester presents two 4-bit operands with a request. The block grants one requester at a time and registers the operands into the shared `bit4_multiplier` (ports A, B, Y). It returns the 8-bit product with the requester ID over a valid/ready response channel. It sits between the requester clients and the multiplier datapath.

## Interface
- `NREQ`, default 4: number of requesters; supported range 2..4.
- `IDW`, default 2: requester ID width; must equal ceil(log2(NREQ)).
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous active-low reset.
- `req`  in  NREQ: per-requester request level.
- `a_in`  in  4*NREQ: operand A; requester i uses bits [4i+3:4i].
- `b_in`  in  4*NREQ: operand B; same packing as `a_in`.
- `gnt`  out  NREQ: one-hot, registered, one-cycle pulse; means the operands were captured.
- `rsp_valid`  out  1: a product is available.
- `rsp_id`  out  IDW: ID of the requester that owns the product.
- `rsp_y`  out  8: unsigned product A*B.
- `rsp_ready`  in  1: the consumer accepts the response.
- `busy`  out  1: high whenever the state is not IDLE.

## Operation
- FSM states: IDLE, MUL, RESP.
- IDLE:
  - If any `req` bit is set, select the winner by round-robin search starting at `ptr`.
  - Capture `a_in`/`b_in` of the winner into `op_a`/`op_b` and the winner into `cur_id`.
  - Set `gnt[winner]` for the next cycle and go to MUL.
  - If no request is pending, stay in IDLE.
- MUL:
  - The multiplier is driven from `op_a`/`op_b`.
  - At the clock edge, register Y into `rsp_y` and `cur_id` into `rsp_id`, set `rsp_valid`, and go to RESP.
  - `req` is ignored in this state.
- RESP:
  - Hold `rsp_valid`, `rsp_y`, and `rsp_id` stable while `rsp_ready` is 0.
  - On `rsp_valid && rsp_ready`: clear `rsp_valid`, set `ptr = (cur_id+1) mod NREQ`, and go to IDLE.
- `req` is sampled only in IDLE. A request dropped before its grant leaves no effect.
- A requester must hold `req` and its operands until it sees `gnt`. It drops `req` on the edge after `gnt` unless it wants another operation.
- A `req` still high when the block returns to IDLE counts as a new request.
- `rsp_ready` is ignored while `rsp_valid` is 0.
- Arithmetic: the result is an unsigned 4x4 product zero-extended to 8 bits, so the maximum is 15*15 = 225. There is no overflow.
- Round-robin:
  - `ptr` resets to 0, so requester 0 has first priority after reset.
  - The winner becomes lowest priority for the next arbitration.
  - Pointer arithmetic wraps mod NREQ.

## Timing
- Reset (asynchronous assert, synchronous release) gives:
  - state = IDLE, `ptr` = 0
  - `gnt` = 0, `rsp_valid` = 0, `rsp_y` = 0, `rsp_id` = 0
  - `busy` = 0, `op_a` = 0, `op_b` = 0
- Latency, with edge k being the edge that samples `req` in IDLE:
  - `gnt` is high in the cycle after edge k.
  - `rsp_valid` rises after edge k+1.
  - The earliest handshake is at edge k+2.
- Throughput: one operation per 3 cycles when `rsp_ready` is held high.
- `busy` rises after edge k and falls after the handshake edge.
- `gnt` is never high in two consecutive cycles, and at most one bit is set.
- Reset mid-operation (MUL or RESP):
  - The operation in flight is discarded and no response is produced.
  - Outputs return to their reset values immediately, without waiting for a clock.

## Test plan
- **Single request:** `req[1]` = 1 with A=7, B=15.
  - `gnt` = 4'b0010 for one cycle after the sampling edge.
  - Next cycle: `rsp_valid` = 1, `rsp_id` = 1, `rsp_y` = 105.
  - The handshake then returns the block to IDLE with `busy` = 0.
- **Simultaneous requests:** all four `req` high with operands (5,11), (10,12), (13,2), (15,15); `rsp_ready` = 1.
  - Grants occur in order 0, 1, 2, 3.
  - Products are 55, 120, 26, 225 with matching IDs.
  - Operations are spaced 3 cycles apart.
- **Fairness:** `req[0]` and `req[3]` held continuously.
  - Grants alternate 0, 3, 0, 3, with no starvation.
- **Backpressure:** `rsp_ready` = 0 for 5 cycles during RESP, with A=10, B=12.
  - `rsp_valid` = 1, `rsp_y` = 120, and `rsp_id` stay stable.
  - No new `gnt` is issued.
  - Raising `rsp_ready` completes the handshake in 1 cycle.
- **Reset mid-operation:** assert `rst_n` = 0 during MUL.
  - All outputs read 0 before the next clock edge.
  - After release, a pending `req[2]` is granted first only if no lower-indexed request is present (`ptr` = 0).
- **Boundary operands:** A=0, B=13 gives `rsp_y` = 0; A=15, B=15 gives `rsp_y` = 225.
  - A `req` pulse that rises and falls while the block is in MUL produces no grant.
